// File: rtl/act_unit_scheduler.sv
// Round-robin front end that time-shares one combinational activation unit
// among N_REQ requesters, with a per-requester result register held until consumed.
module act_unit_scheduler #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_z,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           act_z,
  input  logic [7:0]           act_a,
  output logic [N_REQ-1:0]     res_valid,
  output logic [8*N_REQ-1:0]   res_data,
  input  logic [N_REQ-1:0]     res_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     issue_count
);

  logic             stage_valid_reg;
  logic [IDX_W-1:0] stage_tag_reg;
  logic [7:0]       act_z_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [N_REQ-1:0] res_valid_reg;
  logic [7:0]       res_data_reg [N_REQ];
  logic [CNT_W-1:0] issue_count_reg;

  logic [7:0]       req_z_arr [N_REQ];
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] eligible;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign req_z_arr[gi]          = req_z[8*gi +: 8];
      assign res_data[8*gi +: 8]    = res_data_reg[gi];
      // A requester stays blocked from the grant until its result is consumed.
      assign pending[gi]  = (stage_valid_reg && (stage_tag_reg == IDX_W'(gi))) || res_valid_reg[gi];
      assign eligible[gi] = req_valid[gi] && !pending[gi];
    end
  endgenerate

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any && eligible[(int'(ptr_reg) + k) % N_REQ]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'((int'(ptr_reg) + k) % N_REQ);
      end
    end
    if (grant_any && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Explicit wrap keeps the pointer legal for non-power-of-two N_REQ.
  assign ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_reg <= 1'b0;
      stage_tag_reg   <= '0;
      act_z_reg       <= '0;
      ptr_reg         <= '0;
      res_valid_reg   <= '0;
      issue_count_reg <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        res_data_reg[i] <= '0;
      end
    end else begin
      stage_valid_reg <= grant_any;
      if (grant_any) begin
        stage_tag_reg <= grant_idx;
        act_z_reg     <= req_z_arr[grant_idx];
        ptr_reg       <= ptr_next;
        if (issue_count_reg != '1) begin
          issue_count_reg <= issue_count_reg + 1'b1;
        end
      end
      // Capture and consume never hit the same lane: pending blocks reissue.
      for (int i = 0; i < N_REQ; i++) begin
        if (stage_valid_reg && (stage_tag_reg == IDX_W'(i))) begin
          res_valid_reg[i] <= 1'b1;
          res_data_reg[i]  <= act_a;
        end else if (res_ready[i]) begin
          res_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign act_z       = act_z_reg;
  assign res_valid   = res_valid_reg;
  assign busy        = stage_valid_reg | (|res_valid_reg);
  assign issue_count = issue_count_reg;

endmodule

// File: doc/act_unit_scheduler.md
Name: act_unit_scheduler

Overview:
Round-robin scheduler that shares one combinational 8-bit LUT+interpolation activation unit (tanh-linear, address = z[7:4], remaining = z[3:0]) among N_REQ neuron requesters in a layer. Accepts pre-activation values over per-requester valid/ready handshakes. Registers the granted operand into the shared unit. Captures the activation result into a per-requester result register, held until that requester consumes it. Each requester has at most one operation outstanding.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index; equals ceil(log2(N_REQ))
CNT_W, 16, width of the issued-operation counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  N_REQ  requester i presents z on req_z[8i+7:8i]
req_z  input  8*N_REQ  signed 8-bit pre-activation values, flattened
req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
act_z  output  8  registered operand to the shared activation unit (z__value)
act_a  input  8  signed result from the shared activation unit (a), combinational in act_z
res_valid  output  N_REQ  result i available
res_data  output  8*N_REQ  signed 8-bit activation results, flattened
res_ready  input  N_REQ  requester i consumes res_data[8i+7:8i]
busy  output  1  stage_valid OR any res_valid
issue_count  output  CNT_W  number of accepted requests since reset, saturating

Behaviour:
- Reset (rst=1 at edge): stage_valid=0, stage_tag=0, act_z=0, ptr=0, res_valid=0, res_data=0, issue_count=0. req_ready is forced to 0 combinationally while rst=1.
- pending[i] = (stage_valid && stage_tag==i) || res_valid[i].
- eligible[i] = req_valid[i] && !pending[i].
- Arbitration (combinational):
  - Scan i = ptr, ptr+1, ... mod N_REQ.
  - The first eligible i gets req_ready[i]=1. All other req_ready bits are 0.
  - No eligible requester gives req_ready=0.
  - req_ready never depends on res_ready.
- Issue (edge k, grant g):
  - stage_valid<=1, stage_tag<=g, act_z<=req_z[g], ptr<=(g+1) mod N_REQ.
  - issue_count<=issue_count+1, holding at all-ones.
- No grant at edge k:
  - stage_valid<=0.
  - act_z holds its last value; ptr holds.
- Capture (edge k+1, stage_valid=1): res_data[stage_tag]<=act_a, res_valid[stage_tag]<=1.
- Pipeline rates:
  - One issue per cycle sustained; the issue and capture stages overlap.
  - Latency: request accepted at edge k gives res_valid high after edge k+1.
- Consume: res_valid[i] && res_ready[i] at edge clears res_valid[i]. res_data[i] holds its value.
- Simultaneous events:
  - Capture for tag j and consume for tag i≠j at the same edge both take effect.
  - A consume of i and a new request from i at the same edge: no grant to i that cycle, because pending[i] is still 1. i becomes eligible at the next cycle.
- res_ready[i] while res_valid[i]=0 is ignored.
- req_valid may drop without a transfer. The arbiter treats it as withdrawn, with no error.
- Reset mid-operation discards the stage and all results. No res_valid is asserted for in-flight tags after reset.
- Arithmetic: no arithmetic on z/a. Values pass bit-exact between req_z, act_z, act_a and res_data. ptr wraps modulo N_REQ, including non-power-of-2 N_REQ.

Test Plan:
- Single request: req_valid[2]=1, req_z[2]=8'h35, stub act_a=~act_z -> req_ready=4'b0100 at cycle 0, act_z=8'h35 at cycle 1, res_valid[2]=1 and res_data[2]=8'hCA at cycle 2, issue_count=1.
- Full contention: all four valid at once with res_ready=4'hF, z=8'h10,8'h20,8'h30,8'h40 -> grants 0,1,2,3 on consecutive cycles, results 8'hEF,8'hDF,8'hCF,8'hBF each two cycles after their grant, ptr=0 afterwards.
- Backpressure: res_ready[1]=0 with req_valid[1] held -> after the first result, req_ready[1] stays 0 and res_data[1] is stable. Raise res_ready for one cycle -> res_valid[1] clears and req_ready[1]=1 on the following cycle.
- Boundaries: z=8'h80 and 8'h7F through the real tanh-linear unit -> res_data matches the unit's LUT output for address 4'h8/4'h7 with remaining 0/15, sign preserved. Fairness: requesters 0 and 3 continuously valid -> grants alternate 3,0,3,0 once ptr has passed 3.
- Reset mid-operation: assert rst on the cycle after a grant -> res_valid=0, req_ready=0 during reset, issue_count=0, and no result appears afterwards.
- Saturation: CNT_W=4, 20 accepted requests -> issue_count stops at 4'hF.
